// File: rtl/kyber_enc_pkg.sv
// Segment codes, segment lengths and FSM encoding shared by the Kyber encryptor
// input sequencer and its segment lookup table.
package kyber_enc_pkg;

  localparam logic [3:0] TYPE_NONE = 4'd0;
  localparam logic [3:0] TYPE_R    = 4'd1;
  localparam logic [3:0] TYPE_EK   = 4'd2;
  localparam logic [3:0] TYPE_M    = 4'd3;
  localparam logic [3:0] TYPE_S    = 4'd4;

  localparam int SEG_LEN_SMALL = 32;
  localparam int OFF_W         = 11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_FETCH   = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FIN     = 3'd4
  } state_e;

  // Byte count of a segment; the public-key segment grows with the module rank.
  function automatic logic [OFF_W-1:0] seg_len(input logic [3:0] seg_type, input int k);
    logic [OFF_W-1:0] len;
    case (seg_type)
      TYPE_R, TYPE_M, TYPE_S: len = OFF_W'(SEG_LEN_SMALL);
      TYPE_EK:                len = OFF_W'(k * 384 + 32);
      default:                len = {OFF_W{1'b0}};
    endcase
    return len;
  endfunction

  function automatic logic type_valid(input logic [3:0] seg_type);
    return (seg_type >= TYPE_R) && (seg_type <= TYPE_S);
  endfunction

endpackage

// File: rtl/kyber_enc_seg_table.sv
// Combinational lookup: segment code -> staging RAM base address and byte length.
module kyber_enc_seg_table
  import kyber_enc_pkg::*;
#(
  parameter int K       = 3,
  parameter int ADDR_W  = 12,
  parameter int BASE_R  = 0,
  parameter int BASE_EK = 32,
  parameter int BASE_M  = 1216,
  parameter int BASE_S  = 1248
) (
  input  logic [3:0]        seg_type,
  output logic [ADDR_W-1:0] seg_base,
  output logic [OFF_W-1:0]  seg_length
);

  // Base address per segment; unknown codes map to zero length at address zero.
  always_comb begin
    seg_length = seg_len(seg_type, K);
    case (seg_type)
      TYPE_R:  seg_base = ADDR_W'(BASE_R);
      TYPE_EK: seg_base = ADDR_W'(BASE_EK);
      TYPE_M:  seg_base = ADDR_W'(BASE_M);
      TYPE_S:  seg_base = ADDR_W'(BASE_S);
      default: seg_base = {ADDR_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/kyber_enc_input_seq.sv
// Input-loading controller for kyber_pke_enc: serves each requested segment from
// the staging RAM over the readin/readin_ok/full_in handshake until enc_done.
module kyber_enc_input_seq
  import kyber_enc_pkg::*;
#(
  parameter int K       = 3,
  parameter int ADDR_W  = 12,
  parameter int BASE_R  = 0,
  parameter int BASE_EK = 32,
  parameter int BASE_M  = 1216,
  parameter int BASE_S  = 1248
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              load_done,
  output logic              err,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  input  logic [3:0]        input_type,
  input  logic              readin_ok,
  input  logic              enc_done,
  output logic              readin,
  output logic              full_in,
  output logic [3:0]        data_type,
  output logic [7:0]        kyber_din,
  output logic [15:0]       kyber_in_index
);

  state_e            state_q, state_d;
  logic [3:0]        cur_type_q, cur_type_d;
  logic [3:0]        served_type_q, served_type_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic              busy_q, busy_d;
  logic              load_done_q, load_done_d;
  logic              err_q, err_d;
  logic              src_rd_q, src_rd_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic              readin_q, readin_d;
  logic              full_in_q, full_in_d;
  logic [3:0]        data_type_q, data_type_d;
  logic [15:0]       index_q, index_d;
  logic [7:0]        din_q, din_d;
  logic              fresh_q, fresh_d;

  logic [3:0]        tbl_type_s;
  logic [ADDR_W-1:0] tbl_base_s;
  logic [OFF_W-1:0]  tbl_len_s;
  logic [OFF_W-1:0]  next_off_s;
  logic              bad_req_s;

  // In ARM the table resolves the incoming request so the first read issues without a bubble.
  assign tbl_type_s = (state_q == ST_ARM) ? input_type : cur_type_q;
  assign next_off_s = offset_q + 11'd1;
  assign bad_req_s  = enc_done || ((input_type != TYPE_NONE) && (input_type != cur_type_q));

  kyber_enc_seg_table #(
    .K       (K),
    .ADDR_W  (ADDR_W),
    .BASE_R  (BASE_R),
    .BASE_EK (BASE_EK),
    .BASE_M  (BASE_M),
    .BASE_S  (BASE_S)
  ) u_seg_table (
    .seg_type   (tbl_type_s),
    .seg_base   (tbl_base_s),
    .seg_length (tbl_len_s)
  );

  // Next-state and next-output logic of the load sequencer.
  always_comb begin
    state_d       = state_q;
    cur_type_d    = cur_type_q;
    served_type_d = served_type_q;
    offset_d      = offset_q;
    busy_d        = busy_q;
    load_done_d   = 1'b0;
    err_d         = err_q;
    src_rd_d      = 1'b0;
    src_addr_d    = src_addr_q;
    readin_d      = readin_q;
    full_in_d     = full_in_q;
    data_type_d   = data_type_q;
    index_d       = index_q;
    fresh_d       = 1'b0;
    if (fresh_q) begin
      din_d = src_data;
    end else begin
      din_d = din_q;
    end

    if (abort) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      readin_d  = 1'b0;
      full_in_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d       = ST_ARM;
            busy_d        = 1'b1;
            err_d         = 1'b0;
            served_type_d = TYPE_NONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARM: begin
          if (enc_done) begin
            state_d     = ST_FIN;
            load_done_d = 1'b1;
            busy_d      = 1'b0;
          end else if (type_valid(input_type) && (input_type != served_type_q)) begin
            state_d    = ST_FETCH;
            cur_type_d = input_type;
            offset_d   = {OFF_W{1'b0}};
            src_rd_d   = 1'b1;
            src_addr_d = tbl_base_s;
          end else if (input_type > TYPE_S) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_ARM;
          end
        end
        ST_FETCH, ST_PRESENT: begin
          if (bad_req_s) begin
            state_d   = ST_IDLE;
            err_d     = 1'b1;
            busy_d    = 1'b0;
            readin_d  = 1'b0;
            full_in_d = 1'b0;
          end else if (state_q == ST_FETCH) begin
            state_d     = ST_PRESENT;
            readin_d    = 1'b1;
            full_in_d   = (offset_q == (tbl_len_s - 11'd1));
            data_type_d = cur_type_q;
            index_d     = {5'd0, offset_q};
            fresh_d     = 1'b1;
          end else if (readin_ok) begin
            readin_d  = 1'b0;
            full_in_d = 1'b0;
            if (full_in_q) begin
              state_d       = ST_ARM;
              served_type_d = cur_type_q;
            end else begin
              state_d    = ST_FETCH;
              offset_d   = next_off_s;
              src_rd_d   = 1'b1;
              src_addr_d = tbl_base_s + ADDR_W'(next_off_s);
            end
          end else begin
            state_d = ST_PRESENT;
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          readin_d  = 1'b0;
          full_in_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cur_type_q    <= TYPE_NONE;
      served_type_q <= TYPE_NONE;
      offset_q      <= {OFF_W{1'b0}};
      busy_q        <= 1'b0;
      load_done_q   <= 1'b0;
      err_q         <= 1'b0;
      src_rd_q      <= 1'b0;
      src_addr_q    <= {ADDR_W{1'b0}};
      readin_q      <= 1'b0;
      full_in_q     <= 1'b0;
      data_type_q   <= 4'd0;
      index_q       <= 16'd0;
      din_q         <= 8'd0;
      fresh_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_type_q    <= cur_type_d;
      served_type_q <= served_type_d;
      offset_q      <= offset_d;
      busy_q        <= busy_d;
      load_done_q   <= load_done_d;
      err_q         <= err_d;
      src_rd_q      <= src_rd_d;
      src_addr_q    <= src_addr_d;
      readin_q      <= readin_d;
      full_in_q     <= full_in_d;
      data_type_q   <= data_type_d;
      index_q       <= index_d;
      din_q         <= din_d;
      fresh_q       <= fresh_d;
    end
  end

  // The RAM's output register supplies the byte in the first PRESENT cycle; din_q holds it through stalls.
  assign kyber_din      = fresh_q ? src_data : din_q;
  assign busy           = busy_q;
  assign load_done      = load_done_q;
  assign err            = err_q;
  assign src_rd         = src_rd_q;
  assign src_addr       = src_addr_q;
  assign readin         = readin_q;
  assign full_in        = full_in_q;
  assign data_type      = data_type_q;
  assign kyber_in_index = index_q;

endmodule

// File: tb/tb_kyber_enc_input_seq.sv
// Self-checking bench for kyber_enc_input_seq: staging RAM model plus a scoreboard of expected bytes.
module tb_kyber_enc_input_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, enc_done, readin_ok;
  logic [3:0]  input_type;
  logic        busy, load_done, err, src_rd, readin, full_in;
  logic [11:0] src_addr;
  logic [7:0]  src_data = 8'd0;
  logic [3:0]  data_type;
  logic [7:0]  kyber_din;
  logic [15:0] kyber_in_index;

  typedef struct packed {
    logic [3:0]  dtype;
    logic [15:0] idx;
    logic [7:0]  din;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ram [0:4095];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          hit;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (src_rd) src_data <= ram[src_addr];
  end

  kyber_enc_input_seq dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .busy           (busy),
    .load_done      (load_done),
    .err            (err),
    .src_rd         (src_rd),
    .src_addr       (src_addr),
    .src_data       (src_data),
    .input_type     (input_type),
    .readin_ok      (readin_ok),
    .enc_done       (enc_done),
    .readin         (readin),
    .full_in        (full_in),
    .data_type      (data_type),
    .kyber_din      (kyber_din),
    .kyber_in_index (kyber_in_index)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy_err", {30'd0, busy, err}, 32'd2);
  endtask

  task automatic finish_session();
    input_type = 4'd0;
    enc_done   = 1'b1;
    @(negedge clk);
    enc_done = 1'b0;
    chk("load_done_high", {30'd0, load_done, busy}, 32'd2);
    @(negedge clk);
    chk("load_done_pulse", {30'd0, load_done, busy}, 32'd0);
  endtask

  // Serve one segment request; stop_idx >= 0 returns at the negedge showing that index.
  task automatic run_seg(input logic [3:0] t, input bit bp, input int stop_idx, output bit hit_stop);
    int   len, base, cyc, sent;
    bit   done;
    exp_t e;
    logic [3:0] bp_pat;
    bp_pat = 4'b1001;
    len  = (t == 4'd2) ? 1184 : 32;
    base = (t == 4'd1) ? 0 : (t == 4'd2) ? 32 : (t == 4'd3) ? 1216 : 1248;
    for (int i = 0; i < len; i++) begin
      e.dtype = t;
      e.idx   = 16'(i);
      e.din   = 8'((base + i) & 255);
      e.last  = (i == len - 1);
      sb.push_back(e);
    end
    input_type = t;
    cyc = 0; sent = 0; done = 1'b0; hit_stop = 1'b0;
    while (!done && cyc < 6 * len + 20) begin
      @(negedge clk);
      cyc++;
      readin_ok = bp ? bp_pat[cyc % 4] : 1'b1;
      if (readin) begin
        if (sb.size() == 0) begin
          chk("extra_byte", 32'(sb.size()), 32'd1);
          done = 1'b1;
        end else begin
          e = sb[0];
          chk("stream", {3'd0, data_type, kyber_in_index, kyber_din, full_in}, {3'd0, e});
          if (t == 4'd2 && kyber_in_index == 16'd100) chk("byte100_din", {24'd0, kyber_din}, 32'h84);
          if (stop_idx >= 0 && kyber_in_index == 16'(stop_idx)) begin
            hit_stop = 1'b1;
            done     = 1'b1;
          end else if (readin_ok) begin
            void'(sb.pop_front());
            sent++;
            if (e.last) done = 1'b1;
          end
        end
      end
    end
    if (stop_idx < 0) begin
      chk("seg_complete", {31'd0, done}, 32'd1);
      chk("seg_count", 32'(sent), 32'(len));
      if (!bp) chk("seg_latency", 32'(cyc), 32'(2 * len));
      @(negedge clk);
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) ram[a] = 8'(a);
    reset = 1'b0; start = 1'b0; abort = 1'b0; enc_done = 1'b0;
    readin_ok = 1'b0; input_type = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {11'd0, busy, load_done, err, src_rd, readin, full_in, data_type, kyber_din},
        32'd0);
    chk("reset_addr_idx", {4'd0, src_addr, kyber_in_index}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Full session: 1, 2, 3 (with backpressure), 4, then done.
    pulse_start();
    run_seg(4'd1, 1'b0, -1, hit);
    repeat (5) begin
      @(negedge clk);
      chk("hold_no_refetch", {30'd0, src_rd, readin}, 32'd0);
    end
    run_seg(4'd2, 1'b0, -1, hit);
    run_seg(4'd3, 1'b1, -1, hit);
    run_seg(4'd4, 1'b0, -1, hit);
    finish_session();

    // Request changes mid-segment.
    pulse_start();
    run_seg(4'd1, 1'b0, 10, hit);
    chk("reach_idx10", {31'd0, hit}, 32'd1);
    input_type = 4'd3;
    @(negedge clk);
    chk("type_change_err", {29'd0, err, readin, busy}, 32'd4);
    input_type = 4'd0;
    readin_ok  = 1'b0;
    sb.delete();
    pulse_start();

    // Abort in the middle of the public-key segment, then reload from index 0.
    run_seg(4'd2, 1'b0, 500, hit);
    chk("reach_idx500", {31'd0, hit}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {26'd0, busy, readin, full_in, src_rd, load_done, err}, 32'd0);
    input_type = 4'd0;
    sb.delete();
    @(negedge clk);
    chk("abort_no_done", {30'd0, busy, load_done}, 32'd0);
    pulse_start();
    run_seg(4'd2, 1'b0, -1, hit);
    finish_session();

    // Illegal request code.
    pulse_start();
    input_type = 4'd9;
    @(negedge clk);
    chk("illegal_type", {30'd0, err, busy}, 32'd2);
    input_type = 4'd0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
